// File: rtl/qpd_quadrant_combiner_pkg.sv
// Shared widths, flush sequencer states and the Q1.15 saturation helper for the
// quadrant-photodiode combiner.
//
// Contents:
//   ADC_BIT_SIZE / OUTPUT_BIT_SIZE / OUTPUT_FRAC_SIZE  sample and result formats
//   MAX_AVG_LOG2 / DEFAULT_AVG_LOG2                    averaging exponent range
//   SUB_W / COMB_W / ACC_W                             datapath widths per stage
//   sat_to_q15      clamps an accumulator-width value to Q1.15, flags clipping
//   window_last     last counter value of a 2^k sample window
//   clamp_avg_log2  limits a requested exponent to MAX_AVG_LOG2
package qpd_pkg;

  localparam int ADC_BIT_SIZE     = 16;
  localparam int OUTPUT_BIT_SIZE  = 16;
  localparam int OUTPUT_FRAC_SIZE = 15;
  localparam int MAX_AVG_LOG2     = 8;
  localparam int DEFAULT_AVG_LOG2 = 4;
  localparam int AVG_LOG2_W       = 4;

  localparam int SUB_W  = ADC_BIT_SIZE + 1;
  localparam int COMB_W = ADC_BIT_SIZE + 3;
  localparam int ACC_W  = COMB_W + MAX_AVG_LOG2;

  localparam logic signed [ACC_W-1:0] Q15_MAX = ACC_W'((1 << OUTPUT_FRAC_SIZE) - 1);
  localparam logic signed [ACC_W-1:0] Q15_MIN = ACC_W'(-(1 << OUTPUT_FRAC_SIZE));

  typedef enum logic [1:0] {
    FL_IDLE = 2'd0,
    FL_ONE  = 2'd1,
    FL_TWO  = 2'd2
  } flush_state_t;

  typedef struct packed {
    logic [OUTPUT_BIT_SIZE-1:0] value;
    logic                       hit;
  } sat_t;

  function automatic sat_t sat_to_q15(input logic signed [ACC_W-1:0] v);
    sat_t r;
    if (v > Q15_MAX) begin
      r.value = Q15_MAX[OUTPUT_BIT_SIZE-1:0];
      r.hit   = 1'b1;
    end else if (v < Q15_MIN) begin
      r.value = Q15_MIN[OUTPUT_BIT_SIZE-1:0];
      r.hit   = 1'b1;
    end else begin
      r.value = v[OUTPUT_BIT_SIZE-1:0];
      r.hit   = 1'b0;
    end
    return r;
  endfunction

  // 2^k - 1 computed one bit wider so k = MAX_AVG_LOG2 still yields all ones.
  function automatic logic [MAX_AVG_LOG2-1:0] window_last(input logic [AVG_LOG2_W-1:0] k);
    logic [MAX_AVG_LOG2:0] span;
    span = (MAX_AVG_LOG2+1)'(1) << k;
    span = span - (MAX_AVG_LOG2+1)'(1);
    return span[MAX_AVG_LOG2-1:0];
  endfunction

  function automatic logic [AVG_LOG2_W-1:0] clamp_avg_log2(input logic [AVG_LOG2_W-1:0] k);
    if (k > AVG_LOG2_W'(MAX_AVG_LOG2))
      return AVG_LOG2_W'(MAX_AVG_LOG2);
    return k;
  endfunction

endpackage

// File: rtl/qpd_window_accumulator.sv
// One channel of the box-car averager: accumulates combined samples over a
// 2^k window, scales the window total by 2^(k+2) and saturates it to Q1.15.
//
// Ports:
//   clk, reset    clock, asynchronous active-low reset
//   sample        combined channel value (COMB_W, signed)
//   sample_en     sample is to be accumulated this cycle
//   sample_last   sample closes the current window
//   restart       drop the partial window at this edge
//   k             averaging exponent in force for this window
//   final_valid   scaled window total is waiting to be saturated
//   result        saturated Q1.15 result, held between windows
//   sat_hit       result being registered this cycle is clipped
module qpd_window_accumulator
  import qpd_pkg::*;
(
  input  logic                        clk,
  input  logic                        reset,
  input  logic signed [COMB_W-1:0]    sample,
  input  logic                        sample_en,
  input  logic                        sample_last,
  input  logic                        restart,
  input  logic [AVG_LOG2_W-1:0]       k,
  input  logic                        final_valid,
  output logic [OUTPUT_BIT_SIZE-1:0]  result,
  output logic                        sat_hit
);

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_next;
  logic signed [ACC_W-1:0] final_q;
  logic [4:0]              shift;
  sat_t                    sat_res;

  assign acc_next = acc + ACC_W'(sample);
  // The extra 2 divides the four-quadrant sum back into one-sample scale.
  assign shift    = 5'(k) + 5'd2;
  assign sat_res  = sat_to_q15(final_q);
  assign sat_hit  = final_valid & sat_res.hit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc     <= '0;
      final_q <= '0;
      result  <= '0;
    end else begin
      if (sample_en) begin
        if (sample_last) begin
          final_q <= acc_next >>> shift;
          acc     <= '0;
        end else begin
          acc <= acc_next;
        end
      end
      // A closing sample still produces its result; only the partial sum is lost.
      if (restart)
        acc <= '0;
      if (final_valid)
        result <= sat_res.value;
    end
  end

endmodule

// File: rtl/qpd_quadrant_combiner.sv
// Quadrant-photodiode front end: offset removal, X/Y difference and sum
// forming, 2^k box-car averaging with decimation and Q1.15 saturation.
//
// Ports:
//   clk, reset              clock, asynchronous active-low reset
//   adc_a..adc_d, adc_valid quadrant samples (A TL, B TR, C BL, D BR)
//   offset_a..offset_d      per-quadrant offsets, loaded on offset_update
//   avg_log2, avg_update    averaging exponent, loaded on avg_update
//   clear_overflow          clears the sticky overflow flag
//   XDIFF, YDIFF, SUM       averaged Q1.15 results, held between strobes
//   out_valid               one-cycle strobe when results update
//   overflow                sticky: some channel was clipped
//   busy_flush              restart flush in progress
//
// Flush sequencer
//   state   | meaning
//   FL_IDLE | no restart pending, S3 accepts samples from S2
//   FL_ONE  | first cycle after an update, S2 output discarded
//   FL_TWO  | second cycle after an update, S2 output discarded
module qpd_quadrant_combiner
  import qpd_pkg::*;
(
  input  logic                        clk,
  input  logic                        reset,
  input  logic [ADC_BIT_SIZE-1:0]     adc_a,
  input  logic [ADC_BIT_SIZE-1:0]     adc_b,
  input  logic [ADC_BIT_SIZE-1:0]     adc_c,
  input  logic [ADC_BIT_SIZE-1:0]     adc_d,
  input  logic                        adc_valid,
  input  logic [ADC_BIT_SIZE-1:0]     offset_a,
  input  logic [ADC_BIT_SIZE-1:0]     offset_b,
  input  logic [ADC_BIT_SIZE-1:0]     offset_c,
  input  logic [ADC_BIT_SIZE-1:0]     offset_d,
  input  logic                        offset_update,
  input  logic [AVG_LOG2_W-1:0]       avg_log2,
  input  logic                        avg_update,
  input  logic                        clear_overflow,
  output logic [OUTPUT_BIT_SIZE-1:0]  XDIFF,
  output logic [OUTPUT_BIT_SIZE-1:0]  YDIFF,
  output logic [OUTPUT_BIT_SIZE-1:0]  SUM,
  output logic                        out_valid,
  output logic                        overflow,
  output logic                        busy_flush
);

  logic                            run;
  logic                            accept_in;
  logic                            restart;
  logic signed [ADC_BIT_SIZE-1:0]  off_a, off_b, off_c, off_d;
  logic [AVG_LOG2_W-1:0]           k_reg;
  flush_state_t                    state, state_next;

  logic                            s1_valid;
  logic signed [SUB_W-1:0]         q_a, q_b, q_c, q_d;
  logic signed [COMB_W-1:0]        e_a, e_b, e_c, e_d;
  logic                            s2_valid;
  logic signed [COMB_W-1:0]        x_q, y_q, s_q;

  logic                            acc_en;
  logic                            win_last;
  logic [MAX_AVG_LOG2-1:0]         sample_cnt;
  logic                            final_valid;
  logic                            hit_x, hit_y, hit_s;

  // Deassertion of reset is retimed so the first accepted sample is the one
  // at the second clock edge after release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) run <= 1'b0;
    else        run <= 1'b1;
  end

  assign accept_in = adc_valid & run;
  assign restart   = offset_update | avg_update;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      off_a <= '0;
      off_b <= '0;
      off_c <= '0;
      off_d <= '0;
      k_reg <= AVG_LOG2_W'(DEFAULT_AVG_LOG2);
    end else begin
      if (offset_update) begin
        off_a <= offset_a;
        off_b <= offset_b;
        off_c <= offset_c;
        off_d <= offset_d;
      end
      if (avg_update)
        k_reg <= clamp_avg_log2(avg_log2);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= FL_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy_flush = 1'b0;
    case (state)
      FL_IDLE: state_next = FL_IDLE;
      FL_ONE:  state_next = FL_TWO;
      FL_TWO:  state_next = FL_IDLE;
      default: state_next = FL_IDLE;
    endcase
    if (restart)
      state_next = FL_ONE;
    if (state != FL_IDLE)
      busy_flush = 1'b1;
  end

  // S1: offset removal, one bit of headroom so no clipping is needed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      q_a      <= '0;
      q_b      <= '0;
      q_c      <= '0;
      q_d      <= '0;
    end else begin
      s1_valid <= accept_in;
      if (accept_in) begin
        q_a <= SUB_W'($signed(adc_a)) - SUB_W'(off_a);
        q_b <= SUB_W'($signed(adc_b)) - SUB_W'(off_b);
        q_c <= SUB_W'($signed(adc_c)) - SUB_W'(off_c);
        q_d <= SUB_W'($signed(adc_d)) - SUB_W'(off_d);
      end
    end
  end

  assign e_a = COMB_W'(q_a);
  assign e_b = COMB_W'(q_b);
  assign e_c = COMB_W'(q_c);
  assign e_d = COMB_W'(q_d);

  // S2: left minus right, top minus bottom, and the total.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s2_valid <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      s_q      <= '0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        x_q <= (e_a + e_c) - (e_b + e_d);
        y_q <= (e_a + e_b) - (e_c + e_d);
        s_q <= (e_a + e_b) + (e_c + e_d);
      end
    end
  end

  // S3 control: window counter and result strobes shared by all channels.
  assign acc_en   = s2_valid & ~busy_flush;
  assign win_last = (sample_cnt == window_last(k_reg));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sample_cnt  <= '0;
      final_valid <= 1'b0;
      out_valid   <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      final_valid <= acc_en & win_last;
      if (acc_en)
        sample_cnt <= win_last ? '0 : sample_cnt + MAX_AVG_LOG2'(1);
      if (restart)
        sample_cnt <= '0;
      out_valid <= final_valid;
      if (final_valid & (hit_x | hit_y | hit_s))
        overflow <= 1'b1;
      else if (clear_overflow)
        overflow <= 1'b0;
    end
  end

  qpd_window_accumulator u_acc_x (
    .clk         (clk),
    .reset       (reset),
    .sample      (x_q),
    .sample_en   (acc_en),
    .sample_last (win_last),
    .restart     (restart),
    .k           (k_reg),
    .final_valid (final_valid),
    .result      (XDIFF),
    .sat_hit     (hit_x)
  );

  qpd_window_accumulator u_acc_y (
    .clk         (clk),
    .reset       (reset),
    .sample      (y_q),
    .sample_en   (acc_en),
    .sample_last (win_last),
    .restart     (restart),
    .k           (k_reg),
    .final_valid (final_valid),
    .result      (YDIFF),
    .sat_hit     (hit_y)
  );

  qpd_window_accumulator u_acc_s (
    .clk         (clk),
    .reset       (reset),
    .sample      (s_q),
    .sample_en   (acc_en),
    .sample_last (win_last),
    .restart     (restart),
    .k           (k_reg),
    .final_valid (final_valid),
    .result      (SUM),
    .sat_hit     (hit_s)
  );

endmodule
